dual_port_mem_arbiter: RTL and testbench
========================================

Name: dual_port_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the RV32I core's instruction-fetch port and its load/store port.
- Sits between the core and on-chip memory, replacing separate instruction and data memories with one unified 64 KiB array.
- Arbitration: fixed data-over-instruction priority, with a starvation counter that guarantees fetch progress.
- Gives each port a req/gnt request handshake and a single-cycle rvalid response, and flags out-of-range accesses.

Parameters:
- MEM_BYTES, 65536: size of the backing SRAM in bytes; must be a power of two.
- STARVE_MAX, 4: consecutive denied fetch cycles after which fetch takes priority for one grant.
- AW (localparam), log2(MEM_BYTES/4): SRAM word-address width, 14 at the default.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  32  fetch byte address; bits [1:0] ignored.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch response valid; one cycle after i_gnt.
- i_rdata  out  32  fetched word; 0 when i_err.
- i_err  out  1  qualifies i_rvalid; fetch address was out of range.
- d_req  in  1  data request; held with all d_* inputs stable until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address; bits [1:0] ignored.
- d_wdata  in  32  write data.
- d_wstrb  in  4  byte-lane write enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response (read data or write ack); one cycle after d_gnt.
- d_rdata  out  32  read word; 0 for writes and on d_err.
- d_err  out  1  qualifies d_rvalid; data address was out of range.
- sram_en  out  1  SRAM access enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  AW  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data; valid one cycle after sram_en with sram_we==0.

Behaviour:
- Reset: all outputs 0. resp_src=NONE, starve_cnt=0, resp_err=0.
- Reset asserted mid-transaction discards any pending response; no rvalid is produced after resetn rises for a request granted before reset.
- Range check: an address is in range iff addr < MEM_BYTES; sram_addr = addr[AW+1:2].
- Arbitration (combinational in the request cycle):
  - fetch_pri = (starve_cnt == STARVE_MAX).
  - If d_req && (!i_req || !fetch_pri): grant data.
  - Else if i_req: grant fetch.
  - At most one gnt per cycle.
- Grant to an in-range request drives the SRAM in the same cycle:
  - sram_en=1, sram_addr from the request.
  - Data write: sram_we=d_wstrb, sram_wdata=d_wdata.
  - Reads: sram_we=0.
- Grant to an out-of-range request: sram_en=0, no SRAM access, write dropped; the response carries err=1.
- d_wstrb==0 on an in-range write: sram_en=1, sram_we=0, no data change; responds normally with d_err=0.
- Response tracking: registers resp_src ∈ {NONE, INST, DATA} and resp_err capture the grant.
  - Cycle N+1: the matching rvalid=1 for exactly one cycle; err=resp_err.
  - rdata = sram_rdata when resp_src matches, resp_err=0 and the access was a read; otherwise 0.
- Throughput: one grant per cycle, back-to-back. The arbiter never stalls a grant waiting on a response.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle with i_req && !i_gnt.
  - Clears on i_gnt or when i_req=0.
- Simultaneous i_req and d_req with starve_cnt<STARVE_MAX: data wins; starve_cnt increments.
- Simultaneous requests with starve_cnt==STARVE_MAX: fetch wins; starve_cnt clears; data waits one cycle.
- A requester deasserting req without a gnt is a protocol violation; the arbiter's behaviour is undefined.

Decomposition:
- Shared package mem_arb_pkg:
  - resp_src_e enum {NONE, INST, DATA}.
  - MEM_BYTES default.
  - MMIO base constants 32'h1000_0000 (console) and 32'h2000_0000 (test-pass) for future decode.
- One natural sub-module: starve_counter, a saturating counter with clear. Everything else stays flat.

Test Plan:
- Only i_req, i_addr=0x10 with memory[4]=0xDEADBEEF -> i_gnt same cycle; next cycle i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0.
- d_req write, d_addr=0x20, d_wdata=0x11223344, d_wstrb=4'b0101; then read 0x20 over initial 0xAABBCCDD -> first d_rvalid with d_rdata=0; read returns 0xAA22CC44.
- i_req and d_req both held continuously -> d_gnt on cycles 1-4; i_gnt on cycle 5 (STARVE_MAX=4); pattern repeats every 5 cycles with no lost responses.
- d_req read, d_addr=0x0001_0000 -> d_gnt, sram_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0. A write to the same address leaves the SRAM unchanged.
- Back-to-back fetches 0x0, 0x4, 0x8 -> i_gnt three consecutive cycles; i_rvalid three consecutive cycles with data in order.
- Grant a fetch, assert resetn=0 in the next cycle before the edge, release after 3 cycles -> i_rvalid stays 0 throughout; all outputs 0 during reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory arbiter
package mem_arb_pkg;

    // Which port, if any, owns the response slot in the cycle after a grant
    typedef enum logic [1:0] {
        NONE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } resp_src_e;

    localparam int MEM_BYTES_DEFAULT  = 65536;
    localparam int STARVE_MAX_DEFAULT = 4;

    // Reserved for a later MMIO decode stage in front of the arbiter
    localparam logic [31:0] MMIO_CONSOLE_BASE = 32'h1000_0000;
    localparam logic [31:0] MMIO_PASS_BASE    = 32'h2000_0000;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating up-counter with synchronous clear
module starve_counter #(
    parameter int  MAX = 4,
    localparam int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count
);

    // Clear has priority over increment; the count sticks at MAX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CW'(MAX))) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/dual_port_mem_arbiter.sv
// rtl/dual_port_mem_arbiter.sv - fetch/load-store arbiter in front of one single-port SRAM
module dual_port_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int  MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int  STARVE_MAX = STARVE_MAX_DEFAULT,
    localparam int AW         = $clog2(MEM_BYTES / 4)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    localparam int          CW        = $clog2(STARVE_MAX + 1);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    logic [CW-1:0] starve_cnt;
    logic          fetch_pri;
    logic          starve_inc;
    logic          i_ok;
    logic          d_ok;
    resp_src_e     resp_src;
    logic          resp_err;
    logic          resp_rd;
    logic          unused_addr_bits;

    // Byte offsets are ignored: every access is a full aligned word
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    assign i_ok = (i_addr < MEM_LIMIT);
    assign d_ok = (d_addr < MEM_LIMIT);

    // Data wins unless fetch has been starved long enough; nothing is granted in reset
    always_comb begin
        fetch_pri = (starve_cnt == CW'(STARVE_MAX));
        d_gnt     = resetn && d_req && (!i_req || !fetch_pri);
        i_gnt     = resetn && i_req && !d_gnt;
    end

    // Count cycles a pending fetch is passed over; any fetch grant or idle fetch clears it
    assign starve_inc = i_req && !i_gnt;

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .resetn (resetn),
        .inc    (starve_inc),
        .clr    (!starve_inc),
        .count  (starve_cnt)
    );

    // Drive the SRAM in the grant cycle; out-of-range grants never touch it
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'h0;
        if (d_gnt && d_ok) begin
            sram_en   = 1'b1;
            sram_addr = d_addr[AW+1:2];
            if (d_we) begin
                sram_we    = d_wstrb;
                sram_wdata = d_wdata;
            end
        end else if (i_gnt && i_ok) begin
            sram_en   = 1'b1;
            sram_addr = i_addr[AW+1:2];
        end
    end

    // Remember who was granted so the next cycle's response is steered back to them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_src <= NONE;
            resp_err <= 1'b0;
            resp_rd  <= 1'b0;
        end else if (d_gnt) begin
            resp_src <= DATA;
            resp_err <= !d_ok;
            resp_rd  <= !d_we;
        end else if (i_gnt) begin
            resp_src <= INST;
            resp_err <= !i_ok;
            resp_rd  <= 1'b1;
        end else begin
            resp_src <= NONE;
            resp_err <= 1'b0;
            resp_rd  <= 1'b0;
        end
    end

    // Return read data only for a clean read; write acks and errors carry zero
    always_comb begin
        i_rvalid = (resp_src == INST);
        i_err    = i_rvalid && resp_err;
        i_rdata  = (i_rvalid && !resp_err && resp_rd) ? sram_rdata : 32'h0;
        d_rvalid = (resp_src == DATA);
        d_err    = d_rvalid && resp_err;
        d_rdata  = (d_rvalid && !resp_err && resp_rd) ? sram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// tb/tb_dual_port_mem_arbiter.sv - scoreboard bench for dual_port_mem_arbiter
module tb_dual_port_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        int          due;
    } resp_t;

    resp_t       exp_i[$];
    resp_t       exp_d[$];
    resp_t       mi, md;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          w;
    logic        en;
    logic [31:0] mem [0:16383];

    dual_port_mem_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .i_err      (i_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_wstrb    (d_wstrb),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int k);
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    function automatic logic any_out();
        return |{i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                 sram_en, sram_we, sram_addr, sram_wdata};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // SRAM model: request sampled mid-cycle, performed at the following edge
    initial begin : sram_model
        logic        c_en;
        logic [3:0]  c_we;
        logic [13:0] c_addr;
        logic [31:0] c_wdata;
        for (int k = 0; k < 16384; k++) mem[k] = init_val(k);
        mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'hAABB_CCDD;
        forever begin
            @(negedge clk);
            c_en = sram_en; c_we = sram_we; c_addr = sram_addr; c_wdata = sram_wdata;
            @(posedge clk);
            if (c_en) begin
                if (c_we == 4'b0000) sram_rdata <= mem[c_addr];
                for (int b = 0; b < 4; b++)
                    if (c_we[b]) mem[c_addr][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

    // Monitor: pop and compare each response, and flag late or unexpected ones
    always @(negedge clk) begin
        if (resetn) begin
            if (i_rvalid || d_rvalid) check("single_rvalid", {62'b0, i_rvalid, d_rvalid} == 64'd3, 0);
            if (i_rvalid) begin
                if (exp_i.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL i_unexpected_rvalid actual=1 required=0");
                end else begin
                    mi = exp_i.pop_front();
                    check("i_rvalid_cycle", cyc, mi.due);
                    check("i_rdata", i_rdata, mi.data);
                    check("i_err", i_err, mi.err);
                end
            end else if (exp_i.size() > 0 && exp_i[0].due <= cyc) begin
                checks++; failures++;
                $display("FAIL i_missing_rvalid actual=0 required=1");
                void'(exp_i.pop_front());
            end
            if (d_rvalid) begin
                if (exp_d.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL d_unexpected_rvalid actual=1 required=0");
                end else begin
                    md = exp_d.pop_front();
                    check("d_rvalid_cycle", cyc, md.due);
                    check("d_rdata", d_rdata, md.data);
                    check("d_err", d_err, md.err);
                end
            end else if (exp_d.size() > 0 && exp_d[0].due <= cyc) begin
                checks++; failures++;
                $display("FAIL d_missing_rvalid actual=0 required=1");
                void'(exp_d.pop_front());
            end
        end
    end

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                         input bit hold, output int waited);
        i_req = 1'b1; i_addr = addr; waited = 0;
        forever begin
            @(negedge clk);
            if (i_gnt) break;
            waited++;
            if (waited >= 50) begin
                checks++; failures++;
                $display("FAIL i_gnt_timeout actual=0 required=1");
                break;
            end
        end
        if (i_gnt) exp_i.push_back(resp_t'{data: data, err: err, due: cyc + 1});
        @(posedge clk); #1;
        if (!hold) i_req = 1'b0;
    endtask

    task automatic data_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] data, input logic err,
                           input bit hold, output int waited, output logic en_at_gnt);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
        waited = 0; en_at_gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (d_gnt) break;
            waited++;
            if (waited >= 50) begin
                checks++; failures++;
                $display("FAIL d_gnt_timeout actual=0 required=1");
                break;
            end
        end
        if (d_gnt) begin
            en_at_gnt = sram_en;
            exp_d.push_back(resp_t'{data: data, err: err, due: cyc + 1});
        end
        @(posedge clk); #1;
        if (!hold) d_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", any_out(), 0);
        @(posedge clk); #1 resetn = 1'b1;

        // Lone fetch: granted immediately
        fetch(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, w);
        check("fetch_gnt_latency", w, 0);
        repeat (2) @(posedge clk); #1;

        // Partial write then read-back
        data_op(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 1'b0, w, en);
        check("wr_sram_en", en, 1);
        data_op(1'b0, 32'h20, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, 1'b0, w, en);
        repeat (2) @(posedge clk); #1;

        // Both requesters held: four data grants, then one fetch, twice over
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    int wd; logic ed;
                    data_op(1'b0, 32'h40 + 32'(4*k), 32'h0, 4'h0, init_val(16 + k), 1'b0, k < 7, wd, ed);
                end
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    int wf;
                    fetch(32'h60 + 32'(4*k), init_val(24 + k), 1'b0, k < 1, wf);
                end
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("arb_pattern_i", i_gnt, 64'((k % 5) == 4));
                    check("arb_pattern_d", d_gnt, 64'((k % 5) != 4));
                end
            end
        join
        repeat (2) @(posedge clk); #1;

        // Out-of-range accesses respond with err and never reach the SRAM
        data_op(1'b0, 32'h0001_0000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, w, en);
        check("oor_rd_sram_en", en, 0);
        data_op(1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b0, w, en);
        check("oor_wr_sram_en", en, 0);
        data_op(1'b0, 32'h0, 32'h0, 4'h0, init_val(0), 1'b0, 1'b0, w, en);
        fetch(32'h0002_0000, 32'h0, 1'b1, 1'b0, w);

        // Zero-strobe write leaves memory untouched
        data_op(1'b1, 32'h24, 32'h5555_5555, 4'h0, 32'h0, 1'b0, 1'b0, w, en);
        check("wstrb0_sram_en", en, 1);
        data_op(1'b0, 32'h24, 32'h0, 4'h0, init_val(9), 1'b0, 1'b0, w, en);
        repeat (2) @(posedge clk); #1;

        // Back-to-back fetches
        fetch(32'h0, init_val(0), 1'b0, 1'b1, w);
        check("b2b_gnt0", w, 0);
        fetch(32'h4, init_val(1), 1'b0, 1'b1, w);
        check("b2b_gnt1", w, 0);
        fetch(32'h8, init_val(2), 1'b0, 1'b0, w);
        check("b2b_gnt2", w, 0);
        repeat (3) @(posedge clk); #1;

        // Reset lands inside a fetch grant cycle: its response must never appear
        i_req = 1'b1; i_addr = 32'h8;
        @(negedge clk);
        check("rst_pre_gnt", i_gnt, 1);
        resetn = 1'b0;
        #1 check("rst_outputs_now", any_out(), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_outputs_hold", any_out(), 0);
        end
        @(posedge clk); #1;
        i_req = 1'b0; resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_rvalid", i_rvalid, 0);
        end
        @(posedge clk); #1;

        // Traffic resumes after reset
        fetch(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, w);
        check("post_rst_gnt", w, 0);
        repeat (3) @(posedge clk); #1;

        check("exp_i_drained", exp_i.size(), 0);
        check("exp_d_drained", exp_d.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
